perceptron_trainer: RTL and testbench

- Upstream training sequencer for the perceptron.
- Holds a small labelled sample set in internal registers and replays it one sample per cycle, with train asserted, for repeated epochs.
- Scores each perceptron output against its label and stops on the first error-free epoch or when the epoch limit is reached.
- Drives the perceptron's x, train, learning_rate and expected_y inputs and consumes its y output.

---
 rtl/perceptron_pkg.sv | 19 +
 rtl/perceptron_trainer_sample_store.sv | 42 ++++
 rtl/perceptron_trainer.sv | 204 ++++++++++++++++++++
 tb/tb_perceptron_trainer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron training slice.
package perceptron_pkg;

  // Data word width of labels, learning rate and perceptron output.
  localparam int WORD_W = 32;

  // Default perceptron pipeline depth (x presented -> y valid).
  localparam int DEFAULT_LATENCY = 3;

  // Training sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/perceptron_trainer_sample_store.sv
// Labelled sample storage: DEPTH entries of {x, label}, one write port,
// one combinational read port. Contents survive reset by design.
module sample_store
  import perceptron_pkg::*;
#(
  parameter int N      = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [N-2:0]      wr_x,
  input  logic [WORD_W-1:0] wr_label,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [N-2:0]      rd_x,
  output logic [WORD_W-1:0] rd_label
);

  logic [N-2:0]      x_mem     [DEPTH];
  logic [WORD_W-1:0] label_mem [DEPTH];

  // Write one sample; addresses beyond the array are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      x_mem[wr_addr]     <= wr_x;
      label_mem[wr_addr] <= wr_label;
    end
  end

  // Combinational read; out-of-range indices read as zero.
  always_comb begin
    if (int'(rd_addr) < DEPTH) begin
      rd_x     = x_mem[rd_addr];
      rd_label = label_mem[rd_addr];
    end else begin
      rd_x     = {(N-1){1'b0}};
      rd_label = {WORD_W{1'b0}};
    end
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron training sequencer: replays stored samples epoch by epoch,
// scores the perceptron's delayed output against each label and stops on
// the first error-free epoch, the epoch limit, or an abort.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int N          = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int LATENCY    = DEFAULT_LATENCY,
  parameter int EPOCH_W    = 8,
  parameter int MAX_EPOCHS = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [N-2:0]       wr_x,
  input  logic [WORD_W-1:0]  wr_label,
  input  logic [ADDR_W:0]    num_samples,
  input  logic [WORD_W-1:0]  learning_rate,
  input  logic               start,
  input  logic               abort,
  output logic [N-2:0]       p_x,
  output logic               p_train,
  output logic [WORD_W-1:0]  p_learning_rate,
  output logic [WORD_W-1:0]  p_expected_y,
  input  logic [WORD_W-1:0]  p_y,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [EPOCH_W-1:0] epoch_count,
  output logic [ADDR_W:0]    error_count
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DRN_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0]   ERR_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   NS_MAX      = CNT_W'(DEPTH);
  localparam logic [EPOCH_W-1:0] EPOCH_LIMIT = EPOCH_W'(MAX_EPOCHS);
  localparam logic [DRN_W-1:0]   DRAIN_LAST  = DRN_W'(LATENCY);

  state_t            state_r;
  logic [CNT_W-1:0]  ns_r;
  logic [WORD_W-1:0] lr_r;
  logic [ADDR_W-1:0] idx_r;
  logic [DRN_W-1:0]  drain_cnt_r;

  // Delay line stage 0 is the presented sample itself (p_train/p_expected_y).
  logic [LATENCY:1]  dl_valid_r;
  logic [WORD_W-1:0] dl_exp_r [1:LATENCY];

  logic [N-2:0]      rd_x_s;
  logic [WORD_W-1:0] rd_label_s;
  logic [CNT_W-1:0]  ns_in_s;
  logic              store_wr_s;
  logic              abort_run_s;
  logic              score_err_s;
  logic              last_idx_s;

  // Saturating increment for the mismatch counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == ERR_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign store_wr_s  = wr_en & ~busy;
  assign abort_run_s = abort & busy;
  // Requests beyond the storage depth are clamped so the epoch always ends.
  assign ns_in_s     = (num_samples > NS_MAX) ? NS_MAX : num_samples;
  assign score_err_s = dl_valid_r[LATENCY] && (p_y != dl_exp_r[LATENCY]);
  assign last_idx_s  = ({1'b0, idx_r} == (ns_r - CNT_W'(1)));

  sample_store #(
    .N      (N),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk      (clk),
    .wr_en    (store_wr_s),
    .wr_addr  (wr_addr),
    .wr_x     (wr_x),
    .wr_label (wr_label),
    .rd_addr  (idx_r),
    .rd_x     (rd_x_s),
    .rd_label (rd_label_s)
  );

  // Training FSM with registered perceptron drive, status and score counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      ns_r            <= {CNT_W{1'b0}};
      lr_r            <= {WORD_W{1'b0}};
      idx_r           <= {ADDR_W{1'b0}};
      drain_cnt_r     <= {DRN_W{1'b0}};
      p_x             <= {(N-1){1'b0}};
      p_train         <= 1'b0;
      p_learning_rate <= {WORD_W{1'b0}};
      p_expected_y    <= {WORD_W{1'b0}};
      busy            <= 1'b0;
      done            <= 1'b0;
      converged       <= 1'b0;
      epoch_count     <= {EPOCH_W{1'b0}};
      error_count     <= {CNT_W{1'b0}};
    end else if (abort_run_s) begin
      state_r   <= ST_DONE;
      busy      <= 1'b0;
      done      <= 1'b1;
      p_train   <= 1'b0;
      converged <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start && !abort) begin
            ns_r        <= ns_in_s;
            lr_r        <= learning_rate;
            idx_r       <= {ADDR_W{1'b0}};
            epoch_count <= {EPOCH_W{1'b0}};
            error_count <= {CNT_W{1'b0}};
            converged   <= 1'b0;
            if (ns_in_s == {CNT_W{1'b0}}) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state_r <= ST_RUN;
              done    <= 1'b0;
              busy    <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          p_x             <= rd_x_s;
          p_expected_y    <= rd_label_s;
          p_train         <= 1'b1;
          p_learning_rate <= lr_r;
          idx_r           <= idx_r + ADDR_W'(1);
          if (score_err_s) begin
            error_count <= sat_inc(error_count);
          end
          if (last_idx_s) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= {DRN_W{1'b0}};
          end
        end
        ST_DRAIN: begin
          p_train <= 1'b0;
          if (score_err_s) begin
            error_count <= sat_inc(error_count);
          end
          if (drain_cnt_r == DRAIN_LAST) begin
            state_r <= ST_CHECK;
          end else begin
            drain_cnt_r <= drain_cnt_r + DRN_W'(1);
          end
        end
        ST_CHECK: begin
          epoch_count <= epoch_count + EPOCH_W'(1);
          if (error_count == {CNT_W{1'b0}}) begin
            converged <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_r   <= ST_DONE;
          end else if ((epoch_count + EPOCH_W'(1)) == EPOCH_LIMIT) begin
            converged <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_r   <= ST_DONE;
          end else begin
            error_count <= {CNT_W{1'b0}};
            idx_r       <= {ADDR_W{1'b0}};
            state_r     <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          p_train <= 1'b0;
        end
      endcase
    end
  end

  // Score delay line: carries each presented label until its p_y is due.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_valid_r <= {LATENCY{1'b0}};
      for (int i = 1; i <= LATENCY; i++) begin
        dl_exp_r[i] <= {WORD_W{1'b0}};
      end
    end else if (abort_run_s) begin
      dl_valid_r <= {LATENCY{1'b0}};
    end else begin
      dl_valid_r[1] <= p_train;
      dl_exp_r[1]   <= p_expected_y;
      for (int i = 2; i <= LATENCY; i++) begin
        dl_valid_r[i] <= dl_valid_r[i-1];
        dl_exp_r[i]   <= dl_exp_r[i-1];
      end
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer: a perceptron stand-in answers
// each presented sample after LAT cycles according to a per-test policy, and
// an epoch-level reference model predicts the outcome of every run.
module tb_perceptron_trainer;

  localparam int N       = 8;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int LAT     = 3;
  localparam int EPOCH_W = 8;
  localparam int MAX_EP  = 3;

  localparam int MODE_PERFECT = 0;  // y equals the label
  localparam int MODE_ZERO    = 1;  // y is always 0
  localparam int MODE_BAD_S1  = 2;  // only sample 1 of epoch 1 is wrong

  logic              clk = 1'b0;
  logic              rst, wr_en, start, abort;
  logic [ADDR_W-1:0] wr_addr;
  logic [N-2:0]      wr_x;
  logic [31:0]       wr_label, learning_rate, p_y;
  logic [ADDR_W:0]   num_samples;
  logic [N-2:0]      p_x;
  logic              p_train, busy, done, converged;
  logic [31:0]       p_learning_rate, p_expected_y;
  logic [EPOCH_W-1:0] epoch_count;
  logic [ADDR_W:0]   error_count;

  perceptron_trainer #(
    .N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LAT),
    .EPOCH_W(EPOCH_W), .MAX_EPOCHS(MAX_EP)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x),
    .wr_label(wr_label), .num_samples(num_samples), .learning_rate(learning_rate),
    .start(start), .abort(abort), .p_x(p_x), .p_train(p_train),
    .p_learning_rate(p_learning_rate), .p_expected_y(p_expected_y), .p_y(p_y),
    .busy(busy), .done(done), .converged(converged),
    .epoch_count(epoch_count), .error_count(error_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int mode = MODE_PERFECT;
  int run_ns = 1;
  int max_err = 0;
  int done_cycle = -1;

  logic [N-2:0] mem_x     [DEPTH];
  logic [31:0]  mem_label [DEPTH];
  logic [31:0]  y_pipe    [0:LAT];

  int           pres_cycle [$];
  logic [N-2:0] pres_x     [$];
  logic [31:0]  pres_exp   [$];
  logic [31:0]  pres_lr    [$];

  // Cycle counter: cycle t spans the t-th rising edge to the next one.
  always @(posedge clk) cycle <= cycle + 1;

  // Perceptron answer for the idx-th presentation of a run.
  function automatic logic [31:0] resp(input int idx, input int ns);
    int k, e;
    k = idx % ns;
    e = idx / ns;
    case (mode)
      MODE_PERFECT: return mem_label[k];
      MODE_ZERO:    return 32'h0;
      default:      return (e == 0 && k == 1) ? (mem_label[k] ^ 32'h1) : mem_label[k];
    endcase
  endfunction

  // Perceptron stand-in and monitor: records presentations, answers after LAT cycles.
  always @(negedge clk) begin
    logic [31:0] r;
    if (p_train === 1'b1) begin
      r = resp(pres_x.size(), (run_ns == 0) ? 1 : run_ns);
      pres_cycle.push_back(cycle);
      pres_x.push_back(p_x);
      pres_exp.push_back(p_expected_y);
      pres_lr.push_back(p_learning_rate);
    end else begin
      r = $urandom;
    end
    for (int i = LAT; i >= 1; i--) y_pipe[i] = y_pipe[i-1];
    y_pipe[0] = r;
    p_y = y_pipe[LAT];
    if (busy === 1'b1 && int'(error_count) > max_err) max_err = int'(error_count);
    if (done === 1'b1 && done_cycle < 0) done_cycle = cycle;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Epoch-level reference: errors per epoch from the answer policy and labels.
  task automatic model_run(input int ns, output int epochs, output int errs, output bit conv);
    epochs = 0; errs = 0; conv = 1'b0;
    if (ns > 0) begin
      for (int e = 0; e < MAX_EP; e++) begin
        errs = 0;
        for (int k = 0; k < ns; k++) if (resp(e * ns + k, ns) !== mem_label[k]) errs++;
        epochs = e + 1;
        if (errs == 0) begin conv = 1'b1; break; end
      end
    end
    if (errs > 31) errs = 31;
  endtask

  // Number of presentations that differ from the expected replay schedule.
  function automatic int seq_diff(input int ns, input int epochs, input int base, input logic [31:0] lr);
    int bad, j;
    bad = (pres_x.size() != ns * epochs) ? 1 : 0;
    j = 0;
    for (int e = 0; e < epochs; e++) begin
      for (int k = 0; k < ns; k++) begin
        if (j < pres_x.size()) begin
          if (pres_cycle[j] != base + e * (ns + LAT + 2) + k || pres_x[j] !== mem_x[k] ||
              pres_exp[j] !== mem_label[k] || pres_lr[j] !== lr) bad++;
        end
        j++;
      end
    end
    return bad;
  endfunction

  task automatic write_sample(input int a, input logic [N-2:0] x, input logic [31:0] lbl);
    wr_en = 1'b1; wr_addr = a[ADDR_W-1:0]; wr_x = x; wr_label = lbl;
    tick();
    wr_en = 1'b0;
    mem_x[a] = x; mem_label[a] = lbl;
  endtask

  task automatic start_train(input int ns, input int md, input logic [31:0] lr, output int s_cycle);
    mode = md; run_ns = ns;
    pres_cycle.delete(); pres_x.delete(); pres_exp.delete(); pres_lr.delete();
    max_err = 0; done_cycle = -1;
    num_samples = ns[ADDR_W:0]; learning_rate = lr; start = 1'b1;
    s_cycle = cycle;
    tick();
    start = 1'b0;
  endtask

  // Wait for done; optionally attempt writes during the first busy cycles.
  task automatic wait_done(input bit poke, output bit timeout);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      if (poke && n < 5) begin
        wr_en = 1'b1; wr_addr = 4'($urandom); wr_x = 7'($urandom); wr_label = $urandom;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      n++;
    end
    wr_en = 1'b0;
    timeout = (done !== 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vectors++; if ({busy, done, converged, p_train} !== 4'b0000) begin miscompares++; $display("FAIL reset.flags got %b want 0000", {busy, done, converged, p_train}); end
    vectors++; if (epoch_count !== 8'd0) begin miscompares++; $display("FAIL reset.epoch got %0d want 0", epoch_count); end
    vectors++; if (error_count !== 5'd0) begin miscompares++; $display("FAIL reset.errors got %0d want 0", error_count); end
    vectors++; if ({p_x, p_expected_y, p_learning_rate} !== '0) begin miscompares++; $display("FAIL reset.drive got %h/%h/%h want 0", p_x, p_expected_y, p_learning_rate); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_perfect(input int ns);
    int s, ep, er; bit cv, to; logic [31:0] lr;
    lr = $urandom;
    start_train(ns, MODE_PERFECT, lr, s);
    wait_done(1'b0, to);
    model_run(ns, ep, er, cv);
    vectors++; if (to) begin miscompares++; $display("FAIL perfect.timeout done never rose"); end
    vectors++; if (converged !== cv) begin miscompares++; $display("FAIL perfect.converged got %0d want %0d", converged, cv); end
    vectors++; if (int'(epoch_count) !== ep) begin miscompares++; $display("FAIL perfect.epoch got %0d want %0d", epoch_count, ep); end
    vectors++; if (int'(error_count) !== er) begin miscompares++; $display("FAIL perfect.errors got %0d want %0d", error_count, er); end
    vectors++; if (seq_diff(ns, ep, s + 2, lr) != 0) begin miscompares++; $display("FAIL perfect.sequence got %0d bad presentations want 0", seq_diff(ns, ep, s + 2, lr)); end
    vectors++; if (done_cycle != s + 2 + (ep - 1) * (ns + LAT + 2) + ns - 1 + LAT + 2) begin miscompares++; $display("FAIL perfect.done_time got %0d want %0d", done_cycle - s, 2 + (ep - 1) * (ns + LAT + 2) + ns - 1 + LAT + 2); end
  endtask

  task automatic test_always_wrong();
    int s, ep, er; bit cv, to; logic [31:0] lr;
    write_sample(0, 7'h11, 32'h0001_0000);
    write_sample(1, 7'h22, 32'h0001_0000);
    lr = $urandom;
    start_train(2, MODE_ZERO, lr, s);
    wait_done(1'b0, to);
    model_run(2, ep, er, cv);
    vectors++; if (to) begin miscompares++; $display("FAIL wrong.timeout done never rose"); end
    vectors++; if (int'(epoch_count) !== ep) begin miscompares++; $display("FAIL wrong.epoch got %0d want %0d", epoch_count, ep); end
    vectors++; if (int'(error_count) !== er) begin miscompares++; $display("FAIL wrong.errors got %0d want %0d", error_count, er); end
    vectors++; if (converged !== cv) begin miscompares++; $display("FAIL wrong.converged got %0d want %0d", converged, cv); end
    vectors++; if (seq_diff(2, ep, s + 2, lr) != 0) begin miscompares++; $display("FAIL wrong.sequence got %0d bad presentations want 0", seq_diff(2, ep, s + 2, lr)); end
    vectors++; if (pres_cycle.size() < 3 || pres_cycle[2] - pres_cycle[1] != LAT + 3) begin miscompares++; $display("FAIL wrong.epoch_gap got %0d want %0d", (pres_cycle.size() < 3) ? -1 : pres_cycle[2] - pres_cycle[1], LAT + 3); end
  endtask

  task automatic test_converge(input int ns, input bit poke);
    int s, ep, er; bit cv, to; logic [31:0] lr;
    lr = $urandom;
    start_train(ns, MODE_BAD_S1, lr, s);
    wait_done(poke, to);
    model_run(ns, ep, er, cv);
    vectors++; if (to) begin miscompares++; $display("FAIL converge.timeout ns=%0d", ns); end
    vectors++; if (max_err !== 1) begin miscompares++; $display("FAIL converge.epoch1_errors got %0d want 1", max_err); end
    vectors++; if (int'(epoch_count) !== ep || converged !== cv || int'(error_count) !== er) begin miscompares++; $display("FAIL converge.result ns=%0d got e=%0d c=%0d err=%0d want e=%0d c=%0d err=%0d", ns, epoch_count, converged, error_count, ep, cv, er); end
    vectors++; if (seq_diff(ns, ep, s + 2, lr) != 0) begin miscompares++; $display("FAIL converge.sequence ns=%0d got %0d bad presentations want 0", ns, seq_diff(ns, ep, s + 2, lr)); end
  endtask

  task automatic test_zero_samples();
    int s; bit to;
    start_train(0, MODE_PERFECT, $urandom, s);
    vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL zero.done got done=%0d busy=%0d want 1/0", done, busy); end
    wait_done(1'b0, to);
    repeat (4) tick();
    vectors++; if (epoch_count !== 8'd0 || converged !== 1'b0) begin miscompares++; $display("FAIL zero.status got e=%0d c=%0d want 0/0", epoch_count, converged); end
    vectors++; if (pres_x.size() != 0) begin miscompares++; $display("FAIL zero.train got %0d presentations want 0", pres_x.size()); end
  endtask

  task automatic test_abort_drain();
    int s, d, a, n, er;
    d = $urandom_range(0, LAT);
    write_sample(2, 7'h33, $urandom | 32'h1);
    write_sample(3, 7'h44, $urandom | 32'h1);
    start_train(4, MODE_ZERO, $urandom, s);
    n = 0;
    while (pres_x.size() < 4 && n < 100) begin tick(); n++; end
    vectors++; if (pres_x.size() != 4) begin miscompares++; $display("FAIL abort.reach_drain got %0d presentations want 4", pres_x.size()); end
    repeat (d) tick();
    a = cycle;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    er = 0;
    foreach (pres_cycle[j]) if (pres_cycle[j] + LAT < a) er++;
    vectors++; if (done !== 1'b1 || busy !== 1'b0 || p_train !== 1'b0 || converged !== 1'b0) begin miscompares++; $display("FAIL abort.state got d=%0d b=%0d t=%0d c=%0d want 1/0/0/0", done, busy, p_train, converged); end
    vectors++; if (int'(error_count) !== er) begin miscompares++; $display("FAIL abort.errors got %0d want %0d (abort %0d cycles into drain)", error_count, er, d); end
    vectors++; if (epoch_count !== 8'd0) begin miscompares++; $display("FAIL abort.epoch got %0d want 0", epoch_count); end
    // start together with abort while idle: no run may begin
    pres_x.delete();
    num_samples = 5'd4; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    vectors++; if (busy !== 1'b0 || done !== 1'b1 || pres_x.size() != 0) begin miscompares++; $display("FAIL abort.idle_start got busy=%0d done=%0d pres=%0d want 0/1/0", busy, done, pres_x.size()); end
  endtask

  task automatic test_reset_mid_run();
    int s, n;
    start_train(8, MODE_PERFECT, $urandom, s);
    n = 0;
    while (pres_x.size() < 3 && n < 100) begin tick(); n++; end
    rst = 1'b1;
    #1;
    vectors++; if ({busy, p_train, done, converged} !== 4'b0000) begin miscompares++; $display("FAIL midreset.flags got %b want 0000", {busy, p_train, done, converged}); end
    vectors++; if (epoch_count !== 8'd0 || error_count !== 5'd0) begin miscompares++; $display("FAIL midreset.counters got e=%0d err=%0d want 0/0", epoch_count, error_count); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; abort = 1'b0;
    wr_addr = '0; wr_x = '0; wr_label = '0; num_samples = '0; learning_rate = '0;
    for (int i = 0; i <= LAT; i++) y_pipe[i] = 32'h0;
    test_reset();
    for (int i = 0; i < DEPTH; i++) write_sample(i, 7'($urandom), $urandom | 32'h1);
    test_perfect(4);
    test_perfect($urandom_range(1, DEPTH));
    test_always_wrong();
    test_converge($urandom_range(2, DEPTH - 1), 1'b0);
    test_converge(DEPTH, 1'b1);
    test_zero_samples();
    test_abort_drain();
    test_reset_mid_run();
    test_perfect(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
